mips_multicycle_core: RTL and testbench

- Multi-cycle MIPS32 subset core with its own program counter, internal 32x32 register file and ready/request handshakes to separate instruction and data memories.
- Executes one instruction at a time through a FETCH/DECODE/EXEC/MEM/WB state machine.
- Supports conditional branches, jumps and variable memory latency, none of which the single-cycle datapath had.
- Sits between the instruction-memory and data-memory models at the top of the CPU hierarchy.

---
 rtl/mips_multicycle_core.sv | 254 +++++++++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_core
// Brief    : Multi-cycle MIPS32 subset core (FETCH/DECODE/EXEC/MEM/WB/HALT)
//            with internal 32x32 register file and request/ready handshakes
//            to separate instruction and data memories.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          HALT_ON_ILLEGAL = 1'b1,
    parameter int unsigned WAIT_LIMIT      = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic [31:0] pc,
    output logic        retire,
    output logic        halted
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam bit          WAIT_EN   = (WAIT_LIMIT != 0);
    localparam logic [31:0] WAIT_LAST = 32'(WAIT_LIMIT) - 32'd1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] target_q, target_d;
    logic [31:0] wait_q, wait_d;
    logic        imem_req_q, imem_req_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic        halted_q, halted_d;
    logic [31:0] regs_q [0:31];

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic [31:0] imm_sext, pc_plus4, alu_b, alu_res;
    logic        legal, wait_hit;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm16    = ir_q[15:0];
    assign imm_sext = {{16{imm16[15]}}, imm16};
    assign pc_plus4 = pc_q + 32'd4;
    assign wait_hit = WAIT_EN && (wait_q == WAIT_LAST);

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = alu_q;
    assign dmem_wdata = b_q;
    assign pc         = pc_q;
    assign halted     = halted_q;

    // Instruction legality and ALU result for the latched instruction
    always_comb begin
        legal = 1'b0;
        case (op)
            OP_RTYPE: legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                              (funct == FN_OR)  || (funct == FN_SLT);
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        alu_b   = (op == OP_RTYPE) ? b_q : imm_sext;
        alu_res = a_q + alu_b;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_SUB:  alu_res = a_q - alu_b;
                FN_AND:  alu_res = a_q & alu_b;
                FN_OR:   alu_res = a_q | alu_b;
                FN_SLT:  alu_res = {31'd0, $signed(a_q) < $signed(alu_b)};
                default: alu_res = a_q + alu_b;
            endcase
        end
    end

    // Next-state, datapath updates, register writes and retire pulse
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        target_d = target_q;
        wait_d   = 32'd0;
        retire   = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        case (state_q)
            S_FETCH: begin
                // The first cycle after reset has no request out, so ready is ignored
                if (imem_req_q && imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end else if (imem_req_q && WAIT_EN) begin
                    if (wait_hit) state_d = S_HALT;
                    else          wait_d  = wait_q + 32'd1;
                end
            end
            S_DECODE: begin
                a_d      = regs_q[rs];
                b_d      = regs_q[rt];
                target_d = pc_plus4 + {imm_sext[29:0], 2'b00};
                if (!legal) begin
                    if (HALT_ON_ILLEGAL) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_plus4;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (op == OP_J) begin
                    pc_d    = {pc_plus4[31:28], ir_q[25:0], 2'b00};
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_d = alu_res;
                if (op == OP_BEQ || op == OP_BNE) begin
                    pc_d    = ((a_q == b_q) != (op == OP_BNE)) ? target_q : pc_plus4;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (op == OP_LW || op == OP_SW) begin
                    state_d = (alu_res[1:0] != 2'b00) ? S_HALT : S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_req_q && dmem_ready) begin
                    if (op == OP_SW) begin
                        pc_d    = pc_plus4;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = dmem_rdata;
                        state_d = S_WB;
                    end
                end else if (WAIT_EN) begin
                    if (wait_hit) state_d = S_HALT;
                    else          wait_d  = wait_q + 32'd1;
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = (op == OP_RTYPE) ? rd : rt;
                rf_wdata = (op == OP_LW) ? mdr_q : alu_q;
                pc_d     = pc_plus4;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
        imem_req_d = (state_d == S_FETCH);
        dmem_req_d = (state_d == S_MEM);
        dmem_we_d  = (state_d == S_MEM) && (op == OP_SW);
        halted_d   = (state_d == S_HALT);
    end

    // Control and datapath registers; reset abandons any in-flight request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= 32'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            alu_q      <= 32'd0;
            mdr_q      <= 32'd0;
            target_q   <= 32'd0;
            wait_q     <= 32'd0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            alu_q      <= alu_d;
            mdr_q      <= mdr_d;
            target_q   <= target_d;
            wait_q     <= wait_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            halted_q   <= halted_d;
        end
    end

    // Register file; $0 is never written so it always reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_core
// Brief    : Self-checking bench: memory responders with random latency and
//            an instruction-level reference model of the MIPS subset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_core;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          PCIDX  = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ready = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'd0;
    logic        dmem_req, dmem_we, dmem_ready = 1'b0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 32'd0;
    logic [31:0] pc;
    logic        retire, halted;

    mips_multicycle_core #(
        .RESET_PC(RST_PC), .HALT_ON_ILLEGAL(1'b1), .WAIT_LIMIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .pc(pc), .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] imem  [0:1023];
    logic [31:0] dmem  [0:255];
    logic [31:0] mdmem [0:255];
    logic [31:0] mregs [0:31];
    logic [31:0] mpc;

    int i_cnt = 0, i_lat = 0, i_last = 0, i_fix = -1;
    int d_cnt = 0, d_lat = 0, d_last = 0, d_fix = -1;
    bit i_stall = 1'b0, d_stall = 1'b0;

    int          dur_log[$];
    logic [31:0] pc_log[$], st_addr_log[$], st_data_log[$];

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, rs[4:0], rt[4:0], imm};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] addr);
        return {6'h02, addr[27:2]};
    endfunction

    // Memory responders: random wait states, stray ready while idle
    initial begin
        forever begin
            @(posedge clk); #1;
            if (imem_req) begin
                if (!i_stall && i_cnt >= i_lat) begin
                    imem_ready = 1'b1; imem_rdata = imem[imem_addr[11:2]]; i_last = i_cnt;
                end else begin
                    imem_ready = 1'b0; imem_rdata = $urandom; i_cnt++;
                end
            end else begin
                i_cnt = 0;
                i_lat = (i_fix >= 0) ? i_fix : int'($urandom_range(0, 3));
                imem_ready = ($urandom_range(0, 3) == 0);
                imem_rdata = $urandom;
            end
            if (dmem_req) begin
                if (!d_stall && d_cnt >= d_lat) begin
                    dmem_ready = 1'b1;
                    if (dmem_we) dmem[dmem_addr[9:2]] = dmem_wdata;
                    dmem_rdata = dmem[dmem_addr[9:2]]; d_last = d_cnt;
                end else begin
                    dmem_ready = 1'b0; dmem_rdata = $urandom; d_cnt++;
                end
            end else begin
                d_cnt = 0;
                d_lat = (d_fix >= 0) ? d_fix : int'($urandom_range(0, 3));
                dmem_ready = ($urandom_range(0, 3) == 0);
                dmem_rdata = $urandom;
            end
        end
    end

    // Instruction-level reference: execute the word at mpc, report its cost
    task automatic model_step(output int base, output bit mem, output bit st,
                              output logic [31:0] saddr, output logic [31:0] sdata);
        logic [31:0] ins, rsv, rtv, simm, nxt, res;
        int rs, rt, rd, wr;
        ins = imem[mpc[11:2]];
        rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
        rsv = mregs[rs]; rtv = mregs[rt];
        simm = {{16{ins[15]}}, ins[15:0]};
        nxt = mpc + 32'd4; mem = 1'b0; st = 1'b0; saddr = 32'd0; sdata = 32'd0;
        base = 4; wr = 0; res = 32'd0;
        case (ins[31:26])
            6'h00: begin
                wr = rd;
                case (ins[5:0])
                    6'h20: res = rsv + rtv;
                    6'h22: res = rsv - rtv;
                    6'h24: res = rsv & rtv;
                    6'h25: res = rsv | rtv;
                    default: res = ($signed(rsv) < $signed(rtv)) ? 32'd1 : 32'd0;
                endcase
            end
            6'h08: begin wr = rt; res = rsv + simm; end
            6'h23: begin base = 5; mem = 1'b1; saddr = rsv + simm; wr = rt; res = mdmem[saddr[9:2]]; end
            6'h2B: begin mem = 1'b1; st = 1'b1; saddr = rsv + simm; sdata = rtv; mdmem[saddr[9:2]] = rtv; end
            6'h04: begin base = 3; if (rsv == rtv) nxt = mpc + 32'd4 + (simm << 2); end
            6'h05: begin base = 3; if (rsv != rtv) nxt = mpc + 32'd4 + (simm << 2); end
            default: begin base = 2; nxt = {nxt[31:28], ins[25:0], 2'b00}; end
        endcase
        if (wr != 0) mregs[wr] = res;
        mpc = nxt;
    endtask

    task automatic start_reset();
        logic [31:0] w;
        rst_n = 1'b0; i_stall = 1'b0; d_stall = 1'b0; i_fix = -1; d_fix = -1;
        for (int i = 0; i < 1024; i++) imem[i] = 32'd0;
        for (int i = 0; i < 256; i++) begin w = $urandom; dmem[i] = w; mdmem[i] = w; end
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mpc = RST_PC;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Run until n retirements, checking PC, latency and stores against the model
    task automatic run_prog(input int n);
        int cyc, done, guard, base, expc;
        bit mem, st;
        logic [31:0] cur, saddr, sdata;
        dur_log.delete(); pc_log.delete(); st_addr_log.delete(); st_data_log.delete();
        cyc = 0; done = 0; guard = 0;
        while (done < n && guard < 3000) begin
            @(negedge clk); cyc++; guard++;
            if (halted) break;
            if (retire) begin
                cur = mpc;
                model_step(base, mem, st, saddr, sdata);
                checks++;
                if (pc !== cur) begin failures++; $display("FAIL retire_pc got=%h exp=%h", pc, cur); end
                expc = base + i_last + (mem ? d_last : 0);
                checks++;
                if (cyc !== expc) begin failures++; $display("FAIL latency pc=%h got=%0d exp=%0d", cur, cyc, expc); end
                if (st) begin
                    checks++;
                    if ({dmem_req, dmem_we} !== 2'b11) begin failures++; $display("FAIL store_ctl got=%b exp=11", {dmem_req, dmem_we}); end
                    checks++;
                    if (dmem_addr !== saddr) begin failures++; $display("FAIL store_addr got=%h exp=%h", dmem_addr, saddr); end
                    checks++;
                    if (dmem_wdata !== sdata) begin failures++; $display("FAIL store_data got=%h exp=%h", dmem_wdata, sdata); end
                    st_addr_log.push_back(dmem_addr); st_data_log.push_back(dmem_wdata);
                end
                dur_log.push_back(cyc); pc_log.push_back(pc);
                cyc = 0; done++;
            end
        end
        checks++;
        if (done !== n) begin failures++; $display("FAIL run_retired got=%0d exp=%0d", done, n); end
    endtask

    task automatic test_reset();
        start_reset();
        checks++;
        if ({imem_req, dmem_req, dmem_we, retire, halted} !== 5'b0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=00000", {imem_req, dmem_req, dmem_we, retire, halted});
        end
        imem[PCIDX] = enc_i(6'h08, 0, 1, 16'd5);
        release_reset();
        #1;
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL req_before_edge got=%b exp=0", imem_req); end
        @(posedge clk); #2;
        checks++;
        if (imem_req !== 1'b1) begin failures++; $display("FAIL req_first_edge got=%b exp=1", imem_req); end
        checks++;
        if (imem_addr !== RST_PC) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RST_PC); end
        checks++;
        if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    endtask

    task automatic test_alu_mem();
        start_reset();
        i_fix = 0; d_fix = 3;
        imem[PCIDX+0] = enc_i(6'h08, 0, 1, 16'd5);
        imem[PCIDX+1] = enc_i(6'h08, 0, 2, 16'hFFFD);
        imem[PCIDX+2] = enc_r(1, 2, 3, 6'h20);
        imem[PCIDX+3] = enc_r(2, 1, 4, 6'h2A);
        imem[PCIDX+4] = enc_i(6'h2B, 0, 3, 16'd8);
        imem[PCIDX+5] = enc_i(6'h23, 0, 5, 16'd8);
        imem[PCIDX+6] = enc_i(6'h2B, 0, 5, 16'd12);
        imem[PCIDX+7] = enc_i(6'h2B, 0, 4, 16'd16);
        imem[PCIDX+8] = enc_i(6'h04, 0, 0, 16'hFFFF);
        release_reset();
        run_prog(8);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dur_log[k] !== 4) begin failures++; $display("FAIL alu_spacing idx=%0d got=%0d exp=4", k, dur_log[k]); end
        end
        checks++;
        if (dur_log[4] !== 7) begin failures++; $display("FAIL sw_latency got=%0d exp=7", dur_log[4]); end
        checks++;
        if (dur_log[5] !== 8) begin failures++; $display("FAIL lw_latency got=%0d exp=8", dur_log[5]); end
        checks++;
        if ({st_addr_log[0], st_data_log[0]} !== {32'd8, 32'd2}) begin
            failures++; $display("FAIL sw_r3 got=%h/%h exp=8/2", st_addr_log[0], st_data_log[0]);
        end
        checks++;
        if (st_data_log[1] !== 32'd2) begin failures++; $display("FAIL lw_r5 got=%h exp=2", st_data_log[1]); end
        checks++;
        if (st_data_log[2] !== 32'd1) begin failures++; $display("FAIL slt_r4 got=%h exp=1", st_data_log[2]); end
    endtask

    task automatic test_branch();
        start_reset();
        i_fix = 0;
        imem[PCIDX] = enc_j(32'h10);
        imem[4] = enc_i(6'h04, 1, 1, 16'hFFFF);
        release_reset();
        run_prog(4);
        checks++;
        if (dur_log[0] !== 2) begin failures++; $display("FAIL j_latency got=%0d exp=2", dur_log[0]); end
        checks++;
        if (dur_log[1] !== 3) begin failures++; $display("FAIL beq_latency got=%0d exp=3", dur_log[1]); end
        checks++;
        if (pc_log[2] !== 32'h10) begin failures++; $display("FAIL beq_target got=%h exp=10", pc_log[2]); end
        start_reset();
        i_fix = 0;
        imem[PCIDX] = enc_j(32'h10);
        imem[4] = enc_i(6'h05, 1, 1, 16'd4);
        imem[5] = enc_i(6'h04, 0, 0, 16'hFFFF);
        release_reset();
        run_prog(3);
        checks++;
        if (dur_log[1] !== 3) begin failures++; $display("FAIL bne_latency got=%0d exp=3", dur_log[1]); end
        checks++;
        if (pc_log[2] !== 32'h14) begin failures++; $display("FAIL bne_fallthru got=%h exp=14", pc_log[2]); end
    endtask

    task automatic test_illegal();
        int g;
        bit seen;
        start_reset();
        imem[PCIDX] = 32'hFC00_0000;
        release_reset();
        g = 0; seen = 1'b0;
        while (!halted && g < 20) begin @(negedge clk); g++; if (retire) seen = 1'b1; end
        checks++;
        if (halted !== 1'b1) begin failures++; $display("FAIL illegal_halt got=%b exp=1", halted); end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL illegal_retire got=%b exp=0", seen); end
        repeat (5) @(negedge clk);
        checks++;
        if (pc !== RST_PC) begin failures++; $display("FAIL illegal_pc got=%h exp=%h", pc, RST_PC); end
        checks++;
        if ({imem_req, dmem_req, halted} !== 3'b001) begin
            failures++; $display("FAIL halt_outputs got=%b exp=001", {imem_req, dmem_req, halted});
        end
    endtask

    task automatic test_misaligned();
        int g;
        bit seen;
        start_reset();
        imem[PCIDX] = enc_i(6'h23, 0, 5, 16'd6);
        release_reset();
        g = 0; seen = 1'b0;
        while (!halted && g < 30) begin @(negedge clk); g++; if (dmem_req || retire) seen = 1'b1; end
        checks++;
        if (halted !== 1'b1) begin failures++; $display("FAIL misalign_halt got=%b exp=1", halted); end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL misalign_access got=%b exp=0", seen); end
        checks++;
        if (pc !== RST_PC) begin failures++; $display("FAIL misalign_pc got=%h exp=%h", pc, RST_PC); end
    endtask

    task automatic test_wait_limit();
        int g, n;
        start_reset();
        i_stall = 1'b1;
        release_reset();
        g = 0; n = 0;
        while (!halted && g < 50) begin @(negedge clk); g++; if (imem_req) n++; end
        checks++;
        if (halted !== 1'b1) begin failures++; $display("FAIL wait_halt got=%b exp=1", halted); end
        checks++;
        if (n !== 4) begin failures++; $display("FAIL wait_cycles got=%0d exp=4", n); end
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL wait_req_drop got=%b exp=0", imem_req); end
    endtask

    task automatic test_reset_mid_mem();
        int g;
        start_reset();
        imem[PCIDX] = enc_i(6'h23, 0, 5, 16'd8);
        d_stall = 1'b1;
        release_reset();
        g = 0;
        while (!dmem_req && g < 50) begin @(negedge clk); g++; end
        checks++;
        if (dmem_req !== 1'b1) begin failures++; $display("FAIL mid_mem_reach got=%b exp=1", dmem_req); end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dmem_req, imem_req, retire} !== 3'b000) begin
            failures++; $display("FAIL async_drop got=%b exp=000", {dmem_req, imem_req, retire});
        end
        start_reset();
        imem[PCIDX]   = enc_i(6'h2B, 0, 5, 16'd12);
        imem[PCIDX+1] = enc_i(6'h04, 0, 0, 16'hFFFF);
        release_reset();
        run_prog(1);
        checks++;
        if (pc_log[0] !== RST_PC) begin failures++; $display("FAIL restart_pc got=%h exp=%h", pc_log[0], RST_PC); end
        checks++;
        if (st_data_log[0] !== 32'd0) begin failures++; $display("FAIL r5_written got=%h exp=0", st_data_log[0]); end
    endtask

    task automatic test_random();
        int n, ch, off;
        logic [5:0] fns [5];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        for (int it = 0; it < 5; it++) begin
            start_reset();
            n = 16;
            for (int k = 0; k < n; k++) begin
                ch = int'($urandom_range(0, 7));
                off = int'($urandom_range(0, 2));
                case (ch)
                    1: imem[PCIDX+k] = enc_r(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                             int'($urandom_range(0, 7)), fns[$urandom_range(0, 4)]);
                    2: imem[PCIDX+k] = enc_i(6'h2B, 0, int'($urandom_range(0, 7)), 16'(4 * $urandom_range(0, 15)));
                    3: imem[PCIDX+k] = enc_i(6'h23, 0, int'($urandom_range(0, 7)), 16'(4 * $urandom_range(0, 15)));
                    4: imem[PCIDX+k] = enc_i(6'h04, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 16'(off));
                    5: imem[PCIDX+k] = enc_i(6'h05, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 16'(off));
                    6: imem[PCIDX+k] = enc_j(RST_PC + 32'(4 * (k + 1 + off)));
                    default: imem[PCIDX+k] = enc_i(6'h08, int'($urandom_range(0, 7)),
                                                   int'($urandom_range(1, 7)), 16'($urandom));
                endcase
            end
            for (int k = n; k < n + 3; k++) imem[PCIDX+k] = enc_i(6'h04, 0, 0, 16'hFFFF);
            release_reset();
            run_prog(30);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_mem();
        test_branch();
        test_illegal();
        test_misaligned();
        test_wait_limit();
        test_reset_mid_mem();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
